// File: rtl/parity_zero_flags.sv
// parity_zero_flags
//   Registered PF / ZF / SF detection for the execute stage. Takes the ALU
//   result word and operand size and produces the x86 parity, zero and sign
//   flags one cycle later for the EFLAGS update logic.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   valid_in   in   1   in/op_size valid this cycle
//   in         in  32   ALU result word
//   op_size    in   2   0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = reserved
//   valid_out  out  1   registered valid_in
//   pf         out  1   parity of in[7:0] (even -> 1), 0 for reserved size
//   zf8        out  1   in[7:0]  == 0
//   zf16       out  1   in[15:0] == 0
//   zf32       out  1   in[31:0] == 0
//   zf         out  1   zero flag for the selected size, 0 for reserved
//   sf         out  1   sign bit for the selected size, 0 for reserved
module parity_zero_flags (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] in,
    input  logic [1:0]  op_size,
    output logic        valid_out,
    output logic        pf,
    output logic        zf8,
    output logic        zf16,
    output logic        zf32,
    output logic        zf,
    output logic        sf
);

    logic pf_next;
    logic zf8_next;
    logic zf16_next;
    logic zf32_next;
    logic zf_next;
    logic sf_next;

    always_comb begin
        zf8_next  = ~|in[7:0];
        zf16_next = ~|in[15:0];
        zf32_next = ~|in[31:0];
        // Parity always looks at the low byte only; the reserved size forces 0.
        pf_next   = 1'b0;
        zf_next   = 1'b0;
        sf_next   = 1'b0;
        case (op_size)
            2'd0: begin
                pf_next = ~^in[7:0];
                zf_next = zf8_next;
                sf_next = in[7];
            end
            2'd1: begin
                pf_next = ~^in[7:0];
                zf_next = zf16_next;
                sf_next = in[15];
            end
            2'd2: begin
                pf_next = ~^in[7:0];
                zf_next = zf32_next;
                sf_next = in[31];
            end
            default: begin
                pf_next = 1'b0;
                zf_next = 1'b0;
                sf_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            pf        <= 1'b0;
            zf8       <= 1'b0;
            zf16      <= 1'b0;
            zf32      <= 1'b0;
            zf        <= 1'b0;
            sf        <= 1'b0;
        end else begin
            valid_out <= valid_in;
            // Flags keep the last valid result while the stage is idle.
            if (valid_in) begin
                pf   <= pf_next;
                zf8  <= zf8_next;
                zf16 <= zf16_next;
                zf32 <= zf32_next;
                zf   <= zf_next;
                sf   <= sf_next;
            end
        end
    end

endmodule

// File: tb/tb_parity_zero_flags.sv
module tb_parity_zero_flags;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data = 32'h0;
    logic [1:0]  op_size = 2'd0;
    logic        valid_out, pf, zf8, zf16, zf32, zf, sf;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    parity_zero_flags dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .in        (data),
        .op_size   (op_size),
        .valid_out (valid_out),
        .pf        (pf),
        .zf8       (zf8),
        .zf16      (zf16),
        .zf32      (zf32),
        .zf        (zf),
        .sf        (sf)
    );

    always #5 clk = ~clk;

    // Reference model: flags derived from arithmetic on the word itself.
    logic m_vo = 0, m_pf = 0, m_zf8 = 0, m_zf16 = 0, m_zf32 = 0, m_zf = 0, m_sf = 0;

    function automatic int width_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : (sz == 2'd2) ? 32 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_vo, m_pf, m_zf8, m_zf16, m_zf32, m_zf, m_sf} = 7'b0;
        end else begin
            int w;
            longint unsigned v;
            w = width_of(op_size);
            v = longint'(data);
            m_vo = valid_in;
            if (valid_in) begin
                m_zf8  = (v % 256) == 0;
                m_zf16 = (v % 65536) == 0;
                m_zf32 = v == 0;
                m_pf   = (w != 0) && (($countones(data & 32'hFF) % 2) == 0);
                m_zf   = (w != 0) && ((v % (64'd1 << w)) == 0);
                m_sf   = (w != 0) && (((v >> (w - 1)) % 2) == 1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en)
            chk("model", {25'b0, valid_out, pf, zf8, zf16, zf32, zf, sf},
                {25'b0, m_vo, m_pf, m_zf8, m_zf16, m_zf32, m_zf, m_sf});
    end

    // Drive between edges, then look just after the capturing edge.
    task automatic apply(input logic v, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        #2;
        valid_in = v;
        data     = d;
        op_size  = sz;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] par_vec [5];
    logic        par_exp [5];

    initial begin
        par_vec = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0003, 32'h0000_00FF, 32'hFFFF_FF01};
        par_exp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset held with active-looking inputs.
        valid_in = 1'b1;
        data     = 32'hFFFF_FFFF;
        op_size  = 2'd2;
        #1;
        chk("reset_pre_edge", {valid_out, pf, zf8, zf16, zf32, zf, sf}, 7'b0);
        @(posedge clk);
        #1;
        chk("reset_post_edge", {valid_out, pf, zf8, zf16, zf32, zf, sf}, 7'b0);
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        valid_in = 1'b0;
        rst_n    = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply(1'b1, par_vec[i], 2'd2);
            chk($sformatf("parity_%0d", i), pf, par_exp[i]);
        end

        apply(1'b1, 32'h0001_0000, 2'd0);
        chk("zero_widths", {zf8, zf16, zf32}, 3'b110);
        chk("zf_sz0", zf, 1'b1);
        apply(1'b1, 32'h0001_0000, 2'd1);
        chk("zf_sz1", zf, 1'b1);
        apply(1'b1, 32'h0001_0000, 2'd2);
        chk("zf_sz2", zf, 1'b0);
        apply(1'b1, 32'h0001_0000, 2'd3);
        chk("zf_sz3", zf, 1'b0);
        chk("zf_widths_sz3", {zf8, zf16, zf32}, 3'b110);

        apply(1'b1, 32'h0000_8080, 2'd0);
        chk("sf_sz0", sf, 1'b1);
        apply(1'b1, 32'h0000_8080, 2'd1);
        chk("sf_sz1", sf, 1'b1);
        apply(1'b1, 32'h0000_8080, 2'd2);
        chk("sf_sz2", sf, 1'b0);
        apply(1'b1, 32'h8000_0000, 2'd2);
        chk("sf_msb", {sf, zf}, 2'b10);
        apply(1'b1, 32'h0000_0003, 2'd3);
        chk("pf_sz3", {pf, sf}, 2'b00);

        // Back-to-back stream then idle with changed data.
        apply(1'b1, 32'h0, 2'd2);
        chk("stream_zf32_0", zf32, 1'b1);
        apply(1'b1, 32'h1, 2'd2);
        chk("stream_zf32_1", zf32, 1'b0);
        apply(1'b1, 32'h2, 2'd2);
        chk("stream_zf32_2", zf32, 1'b0);
        chk("stream_valid", valid_out, 1'b1);
        apply(1'b0, 32'hFF, 2'd2);
        chk("hold_valid", valid_out, 1'b0);
        chk("hold_flags", {pf, zf8, zf16, zf32, zf, sf}, 6'b000000);
        apply(1'b0, 32'hFF, 2'd0);
        chk("hold_flags_2", {pf, zf8, zf32}, 3'b000);

        // Asynchronous reset between edges while a result is presented.
        apply(1'b1, 32'h0, 2'd2);
        chk("pre_reset_out", {valid_out, zf32, pf}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {valid_out, pf, zf8, zf16, zf32, zf, sf}, 7'b0);
        valid_in = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        apply(1'b1, 32'h0, 2'd0);
        chk("post_reset", {valid_out, zf, pf}, 3'b111);
        apply(1'b0, 32'h0, 2'd0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
